// File: rtl/jtframe_rom_nslots_pkg.sv
// Shared jtframe SDRAM constants and the helper that turns a slot address
// into a 16-bit SDRAM word address.
package jtframe_rom_nslots_pkg;

  localparam int SDRAM_AW = 22;

  typedef logic [SDRAM_AW-1:0] sdram_addr_t;

  // Slot addresses count DW-wide items; the SDRAM counts 16-bit words.
  function automatic sdram_addr_t rom_word_addr(input sdram_addr_t offset,
                                                input sdram_addr_t addr,
                                                input int          dw);
    sdram_addr_t scaled;
    case (dw)
      8:       scaled = addr >> 1;
      16:      scaled = addr;
      default: scaled = addr << 1;
    endcase
    return offset + scaled;
  endfunction

endpackage

// File: rtl/jtframe_rom_nslots_if.sv
// SDRAM read-port bundle between the ROM slot arbiter and the controller.
interface jtframe_rom_nslots_if;
  import jtframe_rom_nslots_pkg::*;

  logic        req;
  sdram_addr_t addr;
  logic        ack;
  logic        rdy;
  logic [31:0] rd;

  modport master (output req, addr, input ack, rdy, rd);
  modport slave  (input req, addr, output ack, rdy, rd);

endinterface

// File: rtl/jtframe_romrq_entry.sv
// One-entry cache for a single ROM slot: valid bit, captured tag and data,
// plus the combinational hit compare against the live slot address.
module jtframe_romrq_entry #(
  parameter int AW = 17,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wtag,
  input  logic [DW-1:0] wdata,
  output logic          ok,
  output logic [DW-1:0] dout
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  // Invalidate has the last word over a fill landing in the same cycle.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d = 1'b1;
      tag_d   = wtag;
      data_d  = wdata;
    end
    if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign ok   = cs & valid_q & (tag_q == addr);
  assign dout = data_q;

endmodule

// File: rtl/jtframe_rom_nslots.sv
// N-slot ROM request arbiter: each slot keeps a one-entry cache and misses
// are serialised onto a single SDRAM read port, one transaction at a time.
module jtframe_rom_nslots
  import jtframe_rom_nslots_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int DW    = 32,
  parameter int AW    = 17,
  parameter int RR    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SLOTS-1:0]          slot_cs,
  input  logic [SLOTS*AW-1:0]       slot_addr,
  input  logic [SLOTS*SDRAM_AW-1:0] slot_offset,
  input  logic [SLOTS-1:0]          slot_clr,
  output logic [SLOTS-1:0]          slot_ok,
  output logic [SLOTS*DW-1:0]       slot_dout,
  output logic                      sdram_req,
  output logic [SDRAM_AW-1:0]       sdram_addr,
  input  logic                      sdram_ack,
  input  logic                      data_rdy,
  input  logic [31:0]               data_read
);

  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_RDY} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  sdram_addr_t   sdram_addr_q, sdram_addr_d;

  logic [SLOTS-1:0] pending;
  logic [SLOTS-1:0] entry_we;
  logic             found;
  logic [SW-1:0]    win;
  logic [SW:0]      cand;
  logic [AW-1:0]    win_addr;
  sdram_addr_t      win_offset;
  logic [SW:0]      slot_inc;
  logic [SW-1:0]    rr_next;
  logic [DW-1:0]    fill_data;
  logic             unused_read;

  always_comb begin
    pending = '0;
    for (int k = 0; k < SLOTS; k++)
      pending[k] = slot_cs[k] & ~slot_ok[k] &
                   ~((state_q != ST_IDLE) && (slot_q == SW'(k)));
  end

  // Round-robin walks the slots starting at the pointer; fixed priority from 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (RR != 0) begin
        cand = {1'b0, rr_ptr_q} + (SW+1)'(i);
        if (cand >= (SW+1)'(SLOTS)) cand = cand - (SW+1)'(SLOTS);
      end else begin
        cand = (SW+1)'(i);
      end
      if (!found && pending[cand[SW-1:0]]) begin
        found = 1'b1;
        win   = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    win_addr   = '0;
    win_offset = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (win == SW'(k)) begin
        win_addr   = slot_addr[k*AW +: AW];
        win_offset = slot_offset[k*SDRAM_AW +: SDRAM_AW];
      end
    end
  end

  assign slot_inc = {1'b0, slot_q} + (SW+1)'(1);
  assign rr_next  = (slot_inc >= (SW+1)'(SLOTS)) ? '0 : slot_inc[SW-1:0];

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    rr_ptr_d     = rr_ptr_q;
    addr_d       = addr_q;
    req_d        = req_q;
    sdram_addr_d = sdram_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d      = ST_ACK;
          slot_d       = win;
          addr_d       = win_addr;
          req_d        = 1'b1;
          sdram_addr_d = rom_word_addr(win_offset, SDRAM_AW'(win_addr), DW);
        end
      end
      ST_ACK: begin
        if (sdram_ack) begin
          state_d = ST_RDY;
          req_d   = 1'b0;
        end
      end
      ST_RDY: begin
        if (data_rdy) begin
          state_d  = ST_IDLE;
          rr_ptr_d = rr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      rr_ptr_q     <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      rr_ptr_q     <= rr_ptr_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

  always_comb begin
    entry_we = '0;
    if (state_q == ST_RDY && data_rdy) entry_we[slot_q] = 1'b1;
  end

  // Byte slots pick their half of the 16-bit word from the captured address.
  generate
    if (DW == 8) begin : g_fill8
      assign fill_data = addr_q[0] ? data_read[15:8] : data_read[7:0];
    end else begin : g_fillw
      assign fill_data = data_read[DW-1:0];
    end
  endgenerate

  assign unused_read = ^data_read;

  for (genvar k = 0; k < SLOTS; k++) begin : g_entry
    jtframe_romrq_entry #(
      .AW(AW),
      .DW(DW)
    ) u_entry (
      .clk  (clk),
      .rst  (rst),
      .cs   (slot_cs[k]),
      .addr (slot_addr[k*AW +: AW]),
      .clr  (slot_clr[k]),
      .we   (entry_we[k]),
      .wtag (addr_q),
      .wdata(fill_data),
      .ok   (slot_ok[k]),
      .dout (slot_dout[k*DW +: DW])
    );
  end

  assign sdram_req  = req_q;
  assign sdram_addr = sdram_addr_q;

endmodule
